sobel_frame_loader: RTL and testbench

Upstream feeder for the Sobel kernel. It accepts one raster-order 8-bit grayscale frame on a valid/ready pixel stream and writes it into the kernel's `indata` RAM port. It then launches the kernel through its `ap_start`/`ap_ready`/`ap_done` control handshake and reports frame completion. While the kernel runs, input is back-pressured so `indata` is never written under the kernel.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_pix_counter.sv | 42 ++++
 rtl/sobel_frame_loader.sv | 127 ++++++++++++
 tb/tb_sobel_frame_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame loader: default geometry, loader FSM
// states and a geometry sanity helper used at elaboration.
package sobel_pkg;

  localparam int DEF_IMG_W  = 512;
  localparam int DEF_IMG_H  = 512;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_PIX_W  = 8;

  localparam int FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // {row, col} addressing only works when the row width is a power of two
  // and the address exactly covers the frame.
  function automatic bit geometry_ok(input int img_w, input int img_h, input int addr_w);
    bit pow2_w;
    pow2_w = (img_w > 0) && ((img_w & (img_w - 1)) == 0);
    return pow2_w && (img_h > 0) && ((longint'(1) << addr_w) == longint'(img_w) * img_h);
  endfunction

endpackage

// File: rtl/sobel_pix_counter.sv
// Raster pixel index counter: enable, synchronous clear, explicit wrap at the
// last index and a flag marking that index.
module sobel_pix_counter
  import sobel_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_IDX = '1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              at_last;

  assign at_last = (cnt_q == LAST_IDX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = at_last;

endmodule

// File: rtl/sobel_frame_loader.sv
// Loads one raster frame into the Sobel kernel's indata RAM, launches the
// kernel through ap_start/ap_ready/ap_done and reports frame completion.
module sobel_frame_loader
  import sobel_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PIX_W-1:0]  s_pix_tdata,
  input  logic              s_pix_tvalid,
  output logic              s_pix_tready,
  input  logic              s_pix_tlast,
  output logic [ADDR_W-1:0] indata_address0,
  output logic              indata_ce0,
  output logic              indata_we0,
  output logic [PIX_W-1:0]  indata_d0,
  output logic              sobel_start,
  input  logic              sobel_ready,
  input  logic              sobel_done,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_tlast
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);

  if (!geometry_ok(IMG_W, IMG_H, ADDR_W)) begin : g_bad_geometry
    $error("sobel_frame_loader: IMG_W must be a power of two and 2**ADDR_W must equal IMG_W*IMG_H");
  end

  loader_state_t     state_q;
  logic              tready_q;
  logic              start_q;
  logic              frame_done_q;
  logic [15:0]       frame_count_q;
  logic              err_tlast_q;

  logic              beat;
  logic              trunc;
  logic [ADDR_W-1:0] pix_cnt;
  logic              pix_last;

  // tready_q is only ever set while in LOAD, so it doubles as the state gate.
  assign beat  = s_pix_tvalid & tready_q;
  assign trunc = beat & s_pix_tlast & ~pix_last;

  sobel_pix_counter #(
    .ADDR_W   (ADDR_W),
    .LAST_IDX (LAST_IDX)
  ) u_pix_counter (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .en_i   (beat),
    .clr_i  (trunc),
    .cnt_o  (pix_cnt),
    .last_o (pix_last)
  );

  // Write path is combinational from the beat; idle values are forced to 0.
  assign indata_ce0      = beat;
  assign indata_we0      = beat;
  assign indata_address0 = beat ? pix_cnt : '0;
  assign indata_d0       = beat ? s_pix_tdata : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= LOAD;
      tready_q      <= 1'b0;
      start_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_tlast_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          tready_q <= 1'b1;
          if (beat) begin
            if (pix_last) begin
              state_q  <= START;
              tready_q <= 1'b0;
              start_q  <= 1'b1;
              if (!s_pix_tlast) err_tlast_q <= 1'b1;
            end else if (s_pix_tlast) begin
              err_tlast_q <= 1'b1;
            end
          end
        end
        START: begin
          if (sobel_ready) begin
            start_q <= 1'b0;
            if (sobel_done) begin
              state_q       <= DONE;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (sobel_done) begin
            state_q       <= DONE;
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        DONE: begin
          state_q  <= LOAD;
          tready_q <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign s_pix_tready = tready_q;
  assign sobel_start  = start_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_tlast    = err_tlast_q;

endmodule

// File: tb/tb_sobel_frame_loader.sv
// Randomized bench for sobel_frame_loader (4x4 frame) with a cycle-stamped
// protocol model and a parameterisable kernel handshake model.
module tb_sobel_frame_loader;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int NP = W * H;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic [7:0]    s_pix_tdata;
  logic          s_pix_tvalid;
  logic          s_pix_tready;
  logic          s_pix_tlast;
  logic [AW-1:0] indata_address0;
  logic          indata_ce0;
  logic          indata_we0;
  logic [7:0]    indata_d0;
  logic          sobel_start;
  logic          sobel_ready;
  logic          sobel_done;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          err_tlast;

  sobel_frame_loader #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(8)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .s_pix_tdata     (s_pix_tdata),
    .s_pix_tvalid    (s_pix_tvalid),
    .s_pix_tready    (s_pix_tready),
    .s_pix_tlast     (s_pix_tlast),
    .indata_address0 (indata_address0),
    .indata_ce0      (indata_ce0),
    .indata_we0      (indata_we0),
    .indata_d0       (indata_d0),
    .sobel_start     (sobel_start),
    .sobel_ready     (sobel_ready),
    .sobel_done      (sobel_done),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .err_tlast       (err_tlast)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Kernel model configuration (changed only while the loader is idle).
  int k_ready_lat = 3;
  int k_done_lat  = 200;
  bit k_together  = 0;
  bit k_spurious  = 0;

  initial begin
    int st_cnt;
    int run_cnt;
    sobel_ready = 1'b0;
    sobel_done  = 1'b0;
    st_cnt  = 0;
    run_cnt = -1;
    forever begin
      @(posedge ap_clk);
      #1;
      sobel_ready = 1'b0;
      sobel_done  = 1'b0;
      if (!ap_rst_n) begin
        st_cnt  = 0;
        run_cnt = -1;
      end else if (run_cnt >= 0) begin
        run_cnt++;
        if (run_cnt == k_done_lat) begin
          sobel_done = 1'b1;
          run_cnt    = -1;
        end
      end else if (sobel_start) begin
        st_cnt++;
        if (st_cnt == k_ready_lat) begin
          sobel_ready = 1'b1;
          st_cnt      = 0;
          if (k_together) sobel_done = 1'b1;
          else            run_cnt = 0;
        end
      end else if (k_spurious) begin
        sobel_ready = ($urandom_range(7) == 0);
        sobel_done  = ($urandom_range(7) == 0);
      end
    end
  end

  // Protocol model: time stamps of last beat, ready and done for the frame
  // in flight; every output is derived from those and the pixel index.
  int  c      = 0;
  int  m_idx  = 0;
  bit  m_err  = 0;
  int  m_fc   = 0;
  int  t_lb   = -1;
  int  t_rd   = -1;
  int  t_dn   = -1;
  bit  fresh  = 1;
  bit  prev_start = 0;
  int  writes_seen  = 0;
  int  fdone_seen   = 0;
  int  start_cycles = 0;
  int  launches     = 0;
  int  start_rise_c = 0;
  int  fdone_c      = 0;
  int  wr_addr_sum  = 0;
  int  wr_data_sum  = 0;

  initial begin
    bit busy, start_exp, fd_exp, tready_exp, beat;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        chk("outputs_in_reset",
            {55'd0, s_pix_tready, indata_ce0, indata_we0, sobel_start, frame_done,
             err_tlast, |indata_address0, |indata_d0, |frame_count}, 64'd0);
        m_idx = 0; m_err = 0; m_fc = 0;
        t_lb = -1; t_rd = -1; t_dn = -1;
        fresh = 1; prev_start = 0;
      end else begin
        c++;
        if (t_dn >= 0 && c == t_dn + 2) begin
          t_lb = -1; t_rd = -1; t_dn = -1;
        end
        busy       = (t_lb >= 0);
        start_exp  = busy && (c > t_lb) && (t_rd < 0 || c <= t_rd);
        fd_exp     = (t_dn >= 0) && (c == t_dn + 1);
        if (fd_exp) m_fc = (m_fc + 1) % 65536;
        tready_exp = !fresh && !busy;
        beat       = s_pix_tvalid && tready_exp;

        chk("tready",      s_pix_tready, tready_exp);
        chk("sobel_start", sobel_start, start_exp);
        chk("frame_done",  frame_done, fd_exp);
        chk("frame_count", frame_count, m_fc);
        chk("err_tlast",   err_tlast, m_err);
        chk("ce0",         indata_ce0, beat);
        chk("we0",         indata_we0, beat);
        chk("address0",    indata_address0, beat ? m_idx : 0);
        chk("d0",          indata_d0, beat ? s_pix_tdata : 8'd0);

        if (indata_ce0) begin
          writes_seen++;
          wr_addr_sum += int'(indata_address0);
          wr_data_sum += int'(indata_d0);
        end
        if (frame_done) begin
          fdone_seen++;
          fdone_c = c;
        end
        if (sobel_start) start_cycles++;
        if (sobel_start && !prev_start) begin
          launches++;
          start_rise_c = c;
        end
        prev_start = sobel_start;

        if (beat) begin
          if (m_idx == NP - 1) begin
            t_lb = c;
            if (!s_pix_tlast) m_err = 1;
            m_idx = 0;
          end else if (s_pix_tlast) begin
            m_err = 1;
            m_idx = 0;
          end else begin
            m_idx++;
          end
        end
        if (start_exp && sobel_ready) begin
          t_rd = c;
          if (sobel_done) t_dn = c;
        end else if (t_rd >= 0 && c > t_rd && t_dn < 0 && sobel_done) begin
          t_dn = c;
        end
        fresh = 0;
      end
    end
  end

  task automatic send_pix(input logic [7:0] d, input logic l, input int gap_pct);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    while ($urandom_range(99) < gap_pct) begin
      s_pix_tvalid = 1'b0;
      @(posedge ap_clk);
      #1;
    end
    s_pix_tvalid = 1'b1;
    s_pix_tdata  = d;
    s_pix_tlast  = l;
    do begin
      @(negedge ap_clk);
      acc = s_pix_tready;
      @(posedge ap_clk);
      #1;
      guard++;
    end while (!acc && guard < 5000);
    if (!acc) chk("accept_timeout", 0, 1);
    s_pix_tvalid = 1'b0;
    s_pix_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input int gap_pct, input bit ramp);
    for (int i = 0; i < n; i++) begin
      send_pix(ramp ? 8'(i) : 8'($urandom), (i == last_at), gap_pct);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!s_pix_tready && g < 3000) begin
      @(posedge ap_clk);
      #1;
      g++;
    end
    if (!s_pix_tready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int w0, f0, s0, l0, a0, d0;
    ap_rst_n     = 1'b0;
    s_pix_tvalid = 1'b0;
    s_pix_tdata  = 8'd0;
    s_pix_tlast  = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("tready_after_reset", s_pix_tready, 1);
    chk("count_after_reset", frame_count, 0);

    // Ramp frame, kernel ready after 3 start cycles and done 200 later.
    w0 = writes_seen; f0 = fdone_seen; s0 = start_cycles; a0 = wr_addr_sum; d0 = wr_data_sum;
    send_frame(NP, NP - 1, 0, 1);
    chk("start_after_last", sobel_start, 1);
    chk("tready_in_start", s_pix_tready, 0);
    wait_idle();
    chk("t1_writes", writes_seen - w0, 16);
    chk("t1_addr_sum", wr_addr_sum - a0, 120);
    chk("t1_data_sum", wr_data_sum - d0, 120);
    chk("t1_start_cycles", start_cycles - s0, 3);
    chk("t1_frame_done_pulses", fdone_seen - f0, 1);
    chk("t1_turnaround", fdone_c - start_rise_c, 203);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_err", err_tlast, 0);

    // ready and done together: START goes straight to DONE.
    k_ready_lat = 3; k_done_lat = 1; k_together = 1;
    f0 = fdone_seen;
    send_frame(NP, NP - 1, 0, 1);
    wait_idle();
    chk("t2_turnaround", fdone_c - start_rise_c, 3);
    chk("t2_frame_done_pulses", fdone_seen - f0, 1);
    chk("t2_frame_count", frame_count, 2);

    // Truncated frame (tlast on pixel 9) then a full frame.
    k_together = 0; k_done_lat = 5;
    l0 = launches; w0 = writes_seen;
    send_frame(10, 9, 0, 1);
    @(posedge ap_clk);
    #1;
    chk("t3_err_set", err_tlast, 1);
    chk("t3_no_launch", launches - l0, 0);
    send_frame(NP, NP - 1, 0, 1);
    wait_idle();
    chk("t3_launches", launches - l0, 1);
    chk("t3_writes", writes_seen - w0, 26);
    chk("t3_err_sticky", err_tlast, 1);
    chk("t3_frame_count", frame_count, 3);

    // Random frames, 50% valid gaps, random kernel timing, stray ready/done in LOAD.
    k_spurious = 1;
    w0 = writes_seen; l0 = launches;
    for (int f = 0; f < 20; f++) begin
      k_ready_lat = $urandom_range(4, 1);
      k_done_lat  = $urandom_range(12, 1);
      k_together  = ($urandom_range(3) == 0);
      send_frame(NP, NP - 1, 50, 0);
      wait_idle();
    end
    k_spurious = 0;
    chk("t4_writes", writes_seen - w0, 20 * NP);
    chk("t4_launches", launches - l0, 20);
    chk("t4_frame_count", frame_count, 23);

    // Reset pulsed while the kernel is running.
    k_ready_lat = 3; k_done_lat = 200; k_together = 0;
    send_frame(NP, NP - 1, 0, 1);
    repeat (20) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("t5_start_drops", sobel_start, 0);
    chk("t5_tready_in_reset", s_pix_tready, 0);
    chk("t5_count_in_reset", frame_count, 0);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("t5_tready_after", s_pix_tready, 1);
    chk("t5_count_after", frame_count, 0);
    chk("t5_err_cleared", err_tlast, 0);
    k_done_lat = 4;
    a0 = wr_addr_sum;
    send_frame(NP, NP - 1, 25, 1);
    wait_idle();
    chk("t5_addr_sum", wr_addr_sum - a0, 120);
    chk("t5_frame_count", frame_count, 1);

    repeat (3) @(posedge ap_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
